// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-unit front end.
//   INSTR_WIDTH / PC_WIDTH : instruction word and program counter widths
//   OPCODE_MSB / OPCODE_LSB: opcode field position inside an instruction word
//   FIFO_DEPTH             : default prefetch queue depth
//   fetch_state_t          : fetch sequencer states
package ctrl_pkg;

    localparam int INSTR_WIDTH = 18;
    localparam int PC_WIDTH    = 10;
    localparam int OPCODE_MSB  = 17;
    localparam int OPCODE_LSB  = 13;
    localparam int FIFO_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(
        input logic [INSTR_WIDTH-1:0] word
    );
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous show-ahead FIFO holding {pc, instruction} pairs.
// The head entry is visible on rdata whenever the queue is not empty and
// reads as zero when it is empty.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   flush      : drop every entry (synchronous, wins over push)
//   push/wdata : write one entry
//   pop        : retire the head entry
//   full/empty : occupancy flags
//   count      : number of stored entries
//   rdata      : head entry
module fetch_fifo #(
    parameter int W     = 28,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [W-1:0]  rdata
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full queue is only accepted when the head leaves in the
    // same cycle; the pointers wrap naturally because DEPTH is a power of two.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: walks pc over a synchronous instruction
// memory, buffers returned words in a show-ahead queue and presents the head
// to the decoder.
// Handshake: a word transfers on every clock edge where instr_valid and
// instr_ready are both high; while instr_valid is high and instr_ready is low,
// raw_instruction and instr_pc hold their value until accepted or flushed.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   start, halt               : sequencer control pulses
//   redirect_valid/redirect_pc: flush and continue at a new pc
//   imem_en/imem_addr         : memory read request (data returns next cycle)
//   imem_rdata                : memory read data
//   raw_instruction/instr_pc  : queue head and its address
//   instr_valid/instr_ready   : decoder handshake
//   dbg_state_o               : current sequencer state
module instruction_fetch #(
    parameter int INSTR_WIDTH = ctrl_pkg::INSTR_WIDTH,
    parameter int PC_WIDTH    = ctrl_pkg::PC_WIDTH,
    parameter int FIFO_DEPTH  = ctrl_pkg::FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     halt,
    input  logic                     redirect_valid,
    input  logic [PC_WIDTH-1:0]      redirect_pc,
    output logic                     imem_en,
    output logic [PC_WIDTH-1:0]      imem_addr,
    input  logic [INSTR_WIDTH-1:0]   imem_rdata,
    output logic [INSTR_WIDTH-1:0]   raw_instruction,
    output logic [PC_WIDTH-1:0]      instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output ctrl_pkg::fetch_state_t   dbg_state_o
);

    import ctrl_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = PC_WIDTH + INSTR_WIDTH;

    fetch_state_t          state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  inflight_q;
    logic [PC_WIDTH-1:0]   inflight_pc_q;

    logic                  issue;
    logic [AW+1:0]         occupancy;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [AW:0]           fifo_count;
    logic [EW-1:0]         fifo_head;

    // Credit check counts the word already in flight but not a pop happening
    // this cycle, so a full queue always waits one cycle before refetching.
    assign occupancy = {1'b0, fifo_count} + (AW+2)'(inflight_q);
    assign issue     = (state_q == RUN) && !redirect_valid
                       && (occupancy < (AW+2)'(FIFO_DEPTH));

    // A redirect in the response cycle kills the returning word.
    assign fifo_push = inflight_q && !redirect_valid;
    assign fifo_pop  = instr_valid && instr_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            RUN: begin
                if (halt) state_d = HALTED;
            end
            HALTED: begin
                // halt beats a simultaneous start
                if (start && !halt) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        if (issue)          pc_d = pc_q + PC_WIDTH'(1);
        if (redirect_valid) pc_d = redirect_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) inflight_pc_q <= pc_q;
        end
    end

    fetch_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (fifo_push),
        .wdata ({inflight_pc_q, imem_rdata}),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .rdata (fifo_head)
    );

    // The credit logic must never let a returning word meet a full queue.
    assert property (@(posedge clk) disable iff (reset)
        fifo_push |-> (!fifo_full || fifo_pop));

    assign imem_en         = issue;
    assign imem_addr       = pc_q;
    assign instr_valid     = !fifo_empty;
    assign instr_pc        = fifo_head[EW-1:INSTR_WIDTH];
    assign raw_instruction = fifo_head[INSTR_WIDTH-1:0];
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import ctrl_pkg::*;

  localparam int IW = 18;
  localparam int PW = 10;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          halt = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [PW-1:0] redirect_pc = '0;
  logic          imem_en;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata = '0;
  logic [IW-1:0] raw_instruction;
  logic [PW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  fetch_state_t  dbg_state;

  instruction_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_en         (imem_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .raw_instruction (raw_instruction),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .dbg_state_o     (dbg_state)
  );

  function automatic logic [IW-1:0] rom_word(input logic [PW-1:0] a);
    return {a[4:0], 3'b000, a};
  endfunction

  // synchronous ROM: data valid the cycle after the request
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= rom_word(imem_addr);
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard
  logic [PW+IW-1:0] exp_q[$];
  logic [PW-1:0]    next_exp_pc = '0;
  fetch_state_t     model_state = IDLE;
  logic             stall_hold = 1'b0;
  logic [PW+IW:0]   held = '0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      next_exp_pc = '0;
      model_state = IDLE;
      stall_hold  = 1'b0;
    end else begin
      check_eq("state", 32'(dbg_state), 32'(model_state));
      if (stall_hold)
        check_eq("head_stable", 32'({instr_valid, instr_pc, raw_instruction}), 32'(held));
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 1);
        else check_eq("xfer", 32'({instr_pc, raw_instruction}), 32'(exp_q.pop_front()));
      end
      if (!instr_valid) check_eq("empty_outputs", 32'({instr_pc, raw_instruction}), 0);
      stall_hold = instr_valid && !instr_ready && !redirect_valid;
      held       = {instr_valid, instr_pc, raw_instruction};
      // stream model: a redirect discards everything not yet accepted
      if (redirect_valid) begin
        exp_q.delete();
        next_exp_pc = redirect_pc;
      end else if (start && model_state == IDLE) begin
        exp_q.delete();
        next_exp_pc = '0;
      end
      case (model_state)
        IDLE:    if (start) model_state = RUN;
        RUN:     if (halt) model_state = HALTED;
        HALTED:  if (start && !halt) model_state = RUN;
        default: model_state = IDLE;
      endcase
      while (exp_q.size() < 8) begin
        exp_q.push_back({next_exp_pc, rom_word(next_exp_pc)});
        next_exp_pc = next_exp_pc + 1'b1;
      end
    end
  end

  // driver tasks: called just after a rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_halt();
    halt = 1'b1;
    step(1);
    halt = 1'b0;
  endtask

  task automatic do_redirect(input logic [PW-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step(1);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_head(input logic [PW-1:0] p, input int max_cycles);
    bit found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      @(posedge clk);
      #1;
      if (instr_valid && instr_pc == p) found = 1'b1;
    end
    check_eq($sformatf("wait_head_%h", p), 32'(found), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    step(3);
    @(negedge clk);
    check_eq("rst_imem_en", 32'(imem_en), 0);
    check_eq("rst_valid", 32'(instr_valid), 0);
    check_eq("rst_raw", 32'(raw_instruction), 0);
    check_eq("rst_pc", 32'(instr_pc), 0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    step(1);
    reset = 1'b0;
    instr_ready = 1'b1;
    step(1);

    // 1: start latency and back-to-back stream
    pulse_start();
    @(negedge clk);
    check_eq("lat_en_n1", 32'(imem_en), 1);
    check_eq("lat_valid_n1", 32'(instr_valid), 0);
    @(negedge clk);
    check_eq("lat_valid_n2", 32'(instr_valid), 0);
    @(negedge clk);
    check_eq("lat_valid_n3", 32'(instr_valid), 1);
    check_eq("lat_pc_n3", 32'(instr_pc), 0);
    repeat (8) begin
      @(negedge clk);
      check_eq("no_gap", 32'(instr_valid), 1);
    end
    step(1);

    // 2: backpressure fills the queue and stops fetching
    instr_ready = 1'b0;
    step(9);
    @(negedge clk);
    check_eq("stall_imem_en", 32'(imem_en), 0);
    check_eq("stall_valid", 32'(instr_valid), 1);
    step(1);
    instr_ready = 1'b1;
    step(10);

    // 3: redirect while the queue holds pc 5.. onwards
    do_redirect(10'h003);
    wait_head(10'h005, 12);
    instr_ready = 1'b0;
    step(4);
    do_redirect(10'h040);
    instr_ready = 1'b1;
    wait_head(10'h040, 10);
    check_eq("redir_data", 32'(raw_instruction), 32'(18'h00040));
    step(6);

    // 4: halt, drain, resume
    do_redirect(10'h00C);
    wait_head(10'h010, 12);
    pulse_halt();
    repeat (12) begin
      @(negedge clk);
      check_eq("halt_imem_en", 32'(imem_en), 0);
    end
    check_eq("halt_drained", 32'(instr_valid), 0);
    step(1);
    pulse_start();
    step(15);

    // 5: redirect to the top of the address space, pc wraps
    do_redirect(10'h3FF);
    wait_head(10'h3FF, 10);
    wait_head(10'h000, 4);
    step(5);

    // 6: reset with a full queue
    instr_ready = 1'b0;
    step(8);
    @(negedge clk);
    check_eq("full_imem_en", 32'(imem_en), 0);
    check_eq("full_valid", 32'(instr_valid), 1);
    step(1);
    reset = 1'b1;
    step(1);
    @(negedge clk);
    check_eq("rst6_valid", 32'(instr_valid), 0);
    check_eq("rst6_imem_en", 32'(imem_en), 0);
    check_eq("rst6_raw", 32'(raw_instruction), 0);
    check_eq("rst6_state", 32'(dbg_state), 32'(IDLE));
    step(1);
    reset = 1'b0;
    instr_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_eq("post_rst_valid", 32'(instr_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
